// File: rtl/riscv_definitions.sv
// Shared definitions for the data-memory bridge.
//   dmb_state_e          : bridge FSM states
//   DMB_TIMEOUT_DEFAULT  : default watchdog limit in cycles
//   BUS_ADDR_ALIGN_MASK  : clears the byte offset of a core address
//   dmb_bus_req_t        : latched address-phase payload
//   dmb_be_legal()       : byte-enable legality for the optional BE check
package riscv_definitions;

   localparam int unsigned DMB_XLEN            = 32;
   localparam int unsigned DMB_BE_W            = 4;
   localparam int unsigned DMB_CNT_W           = 16;
   localparam int unsigned DMB_TIMEOUT_DEFAULT = 255;

   localparam logic [DMB_XLEN-1:0] BUS_ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      DMB_IDLE = 2'd0,
      DMB_ADDR = 2'd1,
      DMB_DATA = 2'd2,
      DMB_DONE = 2'd3
   } dmb_state_e;

   // Address-phase payload held on the bus outputs.
   typedef struct packed {
      logic                we;
      logic [DMB_XLEN-1:0] addr;
      logic [DMB_BE_W-1:0] be;
      logic [DMB_XLEN-1:0] wdata;
   } dmb_bus_req_t;

   // Naturally aligned byte, halfword and word lane patterns only.
   function automatic logic dmb_be_legal(input logic [DMB_BE_W-1:0] be);
      logic ok;
      case (be)
         4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
         default:                   ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dmb_watchdog.sv
// Transaction watchdog for data_mem_bridge.
//   clk, rst_n : clock, synchronous active-low reset
//   clear_i    : restart the count at zero (transaction launch)
//   run_i      : advance the count by one this cycle
//   limit_i    : timeout length in cycles (2..65535)
//   term_o     : registered; high while the count equals limit_i-1
module dmb_watchdog
   import riscv_definitions::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear_i,
   input  logic                 run_i,
   input  logic [DMB_CNT_W-1:0] limit_i,
   output logic                 term_o
);

   logic [DMB_CNT_W-1:0] count_q, count_d;
   logic                 term_q, term_d;

   // Terminal flag is precomputed from the next count so it lines up with count_q.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (run_i) begin
         count_d = count_q + DMB_CNT_W'(1);
      end
      term_d = (count_d == (limit_i - DMB_CNT_W'(1)));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
         term_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         term_q  <= term_d;
      end
   end

   assign term_o = term_q;

endmodule

// File: rtl/data_mem_bridge.sv
// Bridges the core data-memory port to a req/gnt/rvalid system bus.
// Optional feature: define RISCV_DMB_BE_CHECK_EN to reject non-aligned byte
// enables without touching the bus (access completes with rdata=0 and error).
//   clk, rst_n       : clock, synchronous active-low reset
//   i_core_*         : load/store request, held until o_core_ready
//   o_core_ready     : combinational stall release for the memory stage
//   o_core_rdata     : registered full-word read data
//   o_bus_*          : registered address phase (o_bus_req qualifies)
//   i_bus_*          : grant and response channel
//   o_err/o_err_addr : sticky error flag and first failing byte address
// TIMEOUT_CYCLES must lie in 2..65535.
module data_mem_bridge
   import riscv_definitions::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DMB_TIMEOUT_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_core_rd_en,
   input  logic                i_core_wr_en,
   input  logic [DMB_XLEN-1:0] i_core_addr,
   input  logic [DMB_XLEN-1:0] i_core_wdata,
   input  logic [DMB_BE_W-1:0] i_core_be,
   output logic                o_core_ready,
   output logic [DMB_XLEN-1:0] o_core_rdata,
   output logic                o_bus_req,
   output logic                o_bus_we,
   output logic [DMB_XLEN-1:0] o_bus_addr,
   output logic [DMB_BE_W-1:0] o_bus_be,
   output logic [DMB_XLEN-1:0] o_bus_wdata,
   input  logic                i_bus_gnt,
   input  logic                i_bus_rvalid,
   input  logic [DMB_XLEN-1:0] i_bus_rdata,
   input  logic                i_bus_err,
   output logic                o_err,
   output logic [DMB_XLEN-1:0] o_err_addr
);

   localparam logic [DMB_CNT_W-1:0] TO_LIMIT = DMB_CNT_W'(TIMEOUT_CYCLES);

   dmb_state_e          state_q;
   dmb_bus_req_t        bus_q;
   logic                req_q;
   logic [DMB_XLEN-1:0] core_addr_q;
   logic [DMB_XLEN-1:0] rdata_q;
   logic                err_q;
   logic [DMB_XLEN-1:0] err_addr_q;

   logic                access_c;
   logic                be_bad_c;
   logic                launch_c;
   logic                wd_run_c;
   logic                wd_term;
   logic [DMB_XLEN-1:0] err_src_c;

   assign access_c = i_core_rd_en | i_core_wr_en;

`ifdef RISCV_DMB_BE_CHECK_EN
   assign be_bad_c = !dmb_be_legal(i_core_be);
`else
   assign be_bad_c = 1'b0;
`endif

   assign launch_c = (state_q == DMB_IDLE) & access_c & !be_bad_c;
   assign wd_run_c = (state_q == DMB_ADDR) | (state_q == DMB_DATA);

   // In IDLE the failing access is the one on the core port right now.
   assign err_src_c = (state_q == DMB_IDLE) ? i_core_addr : core_addr_q;

   dmb_watchdog u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (launch_c),
      .run_i   (wd_run_c),
      .limit_i (TO_LIMIT),
      .term_o  (wd_term)
   );

   // Bridge FSM; bus outputs hold their value outside ADDR.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= DMB_IDLE;
         bus_q       <= '0;
         req_q       <= 1'b0;
         core_addr_q <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         err_addr_q  <= '0;
      end else begin
         case (state_q)
            DMB_IDLE: begin
               if (access_c) begin
                  if (be_bad_c) begin
                     rdata_q <= '0;
                     err_q   <= 1'b1;
                     if (!err_q) err_addr_q <= err_src_c;
                     state_q <= DMB_DONE;
                  end else begin
                     // Simultaneous read and write resolve to a write.
                     bus_q.we    <= i_core_wr_en;
                     bus_q.addr  <= i_core_addr & BUS_ADDR_ALIGN_MASK;
                     bus_q.be    <= i_core_be;
                     bus_q.wdata <= i_core_wdata;
                     core_addr_q <= i_core_addr;
                     req_q       <= 1'b1;
                     state_q     <= DMB_ADDR;
                  end
               end
            end

            DMB_ADDR: begin
               // Timeout wins over a grant arriving on the terminal cycle.
               if (wd_term) begin
                  req_q   <= 1'b0;
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  if (!err_q) err_addr_q <= err_src_c;
                  state_q <= DMB_DONE;
               end else if (i_bus_gnt) begin
                  req_q   <= 1'b0;
                  state_q <= DMB_DATA;
               end
            end

            DMB_DATA: begin
               // A response on the terminal cycle still completes normally.
               if (i_bus_rvalid) begin
                  if (!bus_q.we) rdata_q <= i_bus_rdata;
                  if (i_bus_err) begin
                     err_q <= 1'b1;
                     if (!err_q) err_addr_q <= err_src_c;
                  end
                  state_q <= DMB_DONE;
               end else if (wd_term) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  if (!err_q) err_addr_q <= err_src_c;
                  state_q <= DMB_DONE;
               end
            end

            DMB_DONE: begin
               state_q <= DMB_IDLE;
            end

            default: begin
               req_q   <= 1'b0;
               state_q <= DMB_IDLE;
            end
         endcase
      end
   end

   assign o_core_ready = (state_q == DMB_DONE) | ((state_q == DMB_IDLE) & !access_c);
   assign o_core_rdata = rdata_q;
   assign o_bus_req    = req_q;
   assign o_bus_we     = bus_q.we;
   assign o_bus_addr   = bus_q.addr;
   assign o_bus_be     = bus_q.be;
   assign o_bus_wdata  = bus_q.wdata;
   assign o_err        = err_q;
   assign o_err_addr   = err_addr_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Self-checking bench for data_mem_bridge (watchdog limit 8).
module tb_data_mem_bridge;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_core_rd_en, i_core_wr_en;
   logic [31:0] i_core_addr, i_core_wdata;
   logic [3:0]  i_core_be;
   logic        o_core_ready;
   logic [31:0] o_core_rdata;
   logic        o_bus_req, o_bus_we;
   logic [31:0] o_bus_addr, o_bus_wdata;
   logic [3:0]  o_bus_be;
   logic        i_bus_gnt, i_bus_rvalid, i_bus_err;
   logic [31:0] i_bus_rdata;
   logic        o_err;
   logic [31:0] o_err_addr;

   always #5 clk = ~clk;

   data_mem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_core_rd_en (i_core_rd_en),
      .i_core_wr_en (i_core_wr_en),
      .i_core_addr  (i_core_addr),
      .i_core_wdata (i_core_wdata),
      .i_core_be    (i_core_be),
      .o_core_ready (o_core_ready),
      .o_core_rdata (o_core_rdata),
      .o_bus_req    (o_bus_req),
      .o_bus_we     (o_bus_we),
      .o_bus_addr   (o_bus_addr),
      .o_bus_be     (o_bus_be),
      .o_bus_wdata  (o_bus_wdata),
      .i_bus_gnt    (i_bus_gnt),
      .i_bus_rvalid (i_bus_rvalid),
      .i_bus_rdata  (i_bus_rdata),
      .i_bus_err    (i_bus_err),
      .o_err        (o_err),
      .o_err_addr   (o_err_addr)
   );

   // gnt_dly / rv_dly of -1 means the slave never answers that phase.
   typedef struct {
      bit          rd, wr;
      logic [31:0] addr, wdata;
      logic [3:0]  be;
      int          gnt_dly, rv_dly;
      logic [31:0] bus_rdata;
      bit          bus_err, noise;
      int          exp_stall, exp_req;
      logic [31:0] exp_rdata;
      bit          exp_err;
      logic [31:0] exp_err_addr;
   } vec_t;

   typedef struct {
      int          stall, req;
      logic [31:0] rdata;
      bit          err;
      logic [31:0] err_addr;
   } exp_t;

   localparam int NV = 12;
   vec_t vecs [NV];
   exp_t exp_q [$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(bit rd, bit wr, logic [31:0] addr, logic [31:0] wdata,
                               logic [3:0] be, int gd, int rvd, logic [31:0] brd, bit berr,
                               bit noise, int st, int rq, logic [31:0] erd, bit eerr,
                               logic [31:0] eea);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be;
      v.gnt_dly = gd; v.rv_dly = rvd; v.bus_rdata = brd; v.bus_err = berr; v.noise = noise;
      v.exp_stall = st; v.exp_req = rq; v.exp_rdata = erd; v.exp_err = eerr;
      v.exp_err_addr = eea;
      return v;
   endfunction

   // Plays the core and a bus slave for one access; the expectation is queued
   // at launch and retired when ready rises.
   task automatic run_vec(input int idx, input vec_t v);
      exp_t e;
      int   stall, reqc, gw, rw, rv_at;
      bit   granted, done;
      string tag;
      stall = 0; reqc = 0; gw = 0; rw = 0; rv_at = -1; granted = 0; done = 0;
      tag = $sformatf("v%0d", idx);
      e.stall = v.exp_stall; e.req = v.exp_req; e.rdata = v.exp_rdata;
      e.err = v.exp_err; e.err_addr = v.exp_err_addr;
      exp_q.push_back(e);
      i_core_rd_en = v.rd; i_core_wr_en = v.wr; i_core_addr = v.addr;
      i_core_wdata = v.wdata; i_core_be = v.be;
      for (int c = 0; c < 40; c++) begin
         i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_err = 1'b0; i_bus_rdata = '0;
         if (o_bus_req) begin
            reqc++;
            if (v.gnt_dly >= 0 && gw == v.gnt_dly) begin
               i_bus_gnt = 1'b1;
               granted   = 1'b1;
               chk({tag, "_bus_addr"},  o_bus_addr,  v.addr & 32'hFFFF_FFFC);
               chk({tag, "_bus_we"},    32'(o_bus_we), 32'(v.wr));
               chk({tag, "_bus_be"},    32'(o_bus_be), 32'(v.be));
               chk({tag, "_bus_wdata"}, o_bus_wdata, v.wdata);
            end else begin
               gw++;
               if (v.noise) begin
                  i_bus_rvalid = 1'b1; i_bus_err = 1'b1; i_bus_rdata = 32'hFFFF_FFFF;
               end
            end
         end else if (granted) begin
            if (v.rv_dly >= 0 && rw == v.rv_dly) begin
               i_bus_rvalid = 1'b1; i_bus_rdata = v.bus_rdata; i_bus_err = v.bus_err;
               rv_at = c; granted = 1'b0;
            end else begin
               rw++;
            end
         end
         #1;
         if (o_core_ready) begin
            e = exp_q.pop_front();
            chk({tag, "_stall"},    32'(stall), 32'(e.stall));
            chk({tag, "_req_cyc"},  32'(reqc),  32'(e.req));
            chk({tag, "_rdata"},    o_core_rdata, e.rdata);
            chk({tag, "_err"},      32'(o_err), 32'(e.err));
            chk({tag, "_err_addr"}, o_err_addr, e.err_addr);
            if (rv_at >= 0) chk({tag, "_rdy_after_rv"}, 32'(c), 32'(rv_at + 1));
            done = 1'b1;
         end else begin
            stall++;
         end
         @(posedge clk); #1;
         if (done) break;
      end
      i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_err = 1'b0; i_bus_rdata = '0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL %s_wait: ready 0 expected 1 within 40 cycles", tag);
         void'(exp_q.pop_front());
      end
   endtask

   logic [31:0] fea;

   initial begin
      rst_n = 1'b0;
      i_core_rd_en = 0; i_core_wr_en = 0; i_core_addr = '0; i_core_wdata = '0; i_core_be = '0;
      i_bus_gnt = 0; i_bus_rvalid = 0; i_bus_rdata = '0; i_bus_err = 0;

`ifdef RISCV_DMB_BE_CHECK_EN
      fea = 32'h5000_0008;
      vecs[5] = mk(1,0,32'h5000_0008,32'h0,4'b0101, 0,0,32'h5555_AAAA,0,0, 1,0,32'h0,       1,fea);
`else
      fea = 32'h3000_0008;
      vecs[5] = mk(1,0,32'h5000_0008,32'h0,4'b0101, 0,0,32'h5555_AAAA,0,0, 3,1,32'h5555_AAAA,0,32'h0);
`endif
      //            rd wr addr          wdata        be       gd rv brdata     be nz  st rq exp_rdata    err ea
      vecs[0]  = mk(1,0,32'h1000_0006,32'h0,        4'b1100, 0, 0,32'hDEAD_BEEF,0,0, 3,1,32'hDEAD_BEEF,0,32'h0);
      vecs[1]  = mk(0,1,32'h2000_0010,32'h1234_5678,4'b1111, 4, 0,32'h0,        0,1, 7,5,32'hDEAD_BEEF,0,32'h0);
      vecs[2]  = mk(1,0,32'h0000_0040,32'h0,        4'b1111, 1, 2,32'hA5A5_0F0F,0,1, 6,2,32'hA5A5_0F0F,0,32'h0);
      vecs[3]  = mk(1,0,32'h0000_0103,32'h0,        4'b0001, 0, 1,32'h0000_00EE,0,0, 4,1,32'h0000_00EE,0,32'h0);
      vecs[4]  = mk(1,1,32'h0000_0046,32'hCAFE_0000,4'b1100, 0, 0,32'h9999_9999,0,0, 3,1,32'h0000_00EE,0,32'h0);
      vecs[6]  = mk(1,0,32'h3000_0008,32'h0,        4'b1111, 0, 0,32'h1111_2222,1,0, 3,1,32'h1111_2222,1,fea);
      vecs[7]  = mk(0,1,32'h3000_0020,32'h0BAD_F00D,4'b1111, 1, 0,32'h0,        1,0, 4,2,32'h1111_2222,1,fea);
      vecs[8]  = mk(1,0,32'h4000_000C,32'h0,        4'b1111,-1, 0,32'h0,        0,0, 9,8,32'h0,        1,fea);
      vecs[9]  = mk(1,0,32'h4000_0010,32'h0,        4'b1111, 0, 0,32'h7777_8888,0,0, 3,1,32'h7777_8888,1,fea);
      vecs[10] = mk(1,0,32'h4000_0014,32'h0,        4'b1111, 0,-1,32'h0,        0,0, 9,1,32'h0,        1,fea);
      vecs[11] = mk(0,1,32'h6000_0000,32'h1357_9BDF,4'b1111, 2, 3,32'h0,        0,0, 8,3,32'h0,        1,fea);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(o_core_ready), 32'd1);
      chk("rst_req",   32'(o_bus_req),    32'd0);
      chk("rst_we",    32'(o_bus_we),     32'd0);
      chk("rst_addr",  o_bus_addr,        32'h0);
      chk("rst_be",    32'(o_bus_be),     32'd0);
      chk("rst_wdata", o_bus_wdata,       32'h0);
      chk("rst_rdata", o_core_rdata,      32'h0);
      chk("rst_err",   32'(o_err),        32'd0);
      chk("rst_eaddr", o_err_addr,        32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++) begin
         run_vec(i, vecs[i]);
         if (i == 8) begin
            // Late response after the timeout must be ignored in IDLE.
            i_core_rd_en = 0; i_core_wr_en = 0;
            i_bus_rvalid = 1'b1; i_bus_rdata = 32'hBADB_AD00; i_bus_err = 1'b1;
            #1;
            chk("stray_idle_ready", 32'(o_core_ready), 32'd1);
            @(posedge clk); #1;
            i_bus_rvalid = 1'b0; i_bus_rdata = '0; i_bus_err = 1'b0;
            chk("stray_idle_rdata", o_core_rdata, 32'h0);
            chk("stray_idle_eaddr", o_err_addr,   fea);
            chk("stray_idle_req",   32'(o_bus_req), 32'd0);
         end
      end

      // Reset while in DATA, then a stray response.
      i_core_rd_en = 1; i_core_wr_en = 0; i_core_addr = 32'h7000_0004; i_core_be = 4'b1111;
      @(posedge clk); #1;
      chk("rstseq_req_addr", 32'(o_bus_req), 32'd1);
      i_bus_gnt = 1'b1;
      @(posedge clk); #1;
      i_bus_gnt = 1'b0;
      chk("rstseq_req_data", 32'(o_bus_req), 32'd0);
      chk("rstseq_err_pre",  32'(o_err),     32'd1);
      rst_n = 1'b0; i_core_rd_en = 0;
      @(posedge clk); #1;
      chk("rstseq_req_rst",   32'(o_bus_req),    32'd0);
      chk("rstseq_ready_rst", 32'(o_core_ready), 32'd1);
      chk("rstseq_err_rst",   32'(o_err),        32'd0);
      rst_n = 1'b1;
      i_bus_rvalid = 1'b1; i_bus_rdata = 32'hFEED_FACE; i_bus_err = 1'b1;
      @(posedge clk); #1;
      i_bus_rvalid = 1'b0; i_bus_rdata = '0; i_bus_err = 1'b0;
      chk("rstseq_rdata", o_core_rdata, 32'h0);
      chk("rstseq_err",   32'(o_err),   32'd0);
      chk("rstseq_eaddr", o_err_addr,   32'h0);
      chk("rstseq_req",   32'(o_bus_req), 32'd0);
      chk("rstseq_ready", 32'(o_core_ready), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_bridge.md
# data_mem_bridge

Bridges the core's data-memory port to a request/grant/response system bus with arbitrary wait states. It sits directly downstream of the core's memory-access stage. It consumes the read/write enables, address, write data and byte-lane control, and it produces the data-ready stall signal and the read data. A watchdog bounds every bus transaction, and bus errors are reported as a sticky flag.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles spent in ADDR+DATA before abort; legal range 2..65535.
- clk  in  1  core clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- i_core_rd_en  in  1  load request; held stable by the core until o_core_ready completes it.
- i_core_wr_en  in  1  store request; same holding rule.
- i_core_addr  in  32  byte address.
- i_core_wdata  in  32  store data, already lane-aligned.
- i_core_be  in  4  byte-lane enables; bit i selects bits [8i+7:8i].
- o_core_ready  out  1  0 stalls the core; 1 means the memory stage may advance.
- o_core_rdata  out  32  registered full-word read data; lane extraction and sign extension belong to the core.
- o_bus_req  out  1  bus request, registered.
- o_bus_we  out  1  1 = write.
- o_bus_addr  out  32  word address; {i_core_addr[31:2],2'b00}.
- o_bus_be  out  4  byte enables.
- o_bus_wdata  out  32  write data.
- i_bus_gnt  in  1  address phase accepted.
- i_bus_rvalid  in  1  response valid; arrives at least 1 cycle after gnt; sent for writes too.
- i_bus_rdata  in  32  response data.
- i_bus_err  in  1  response error, qualified by rvalid.
- o_err  out  1  sticky error flag; cleared only by reset.
- o_err_addr  out  32  i_core_addr of the first erroring access.

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE
  - If rd_en|wr_en, latch addr/be/wdata/we into the bus registers and go to ADDR.
  - If both enables are high, treat the access as a write.
- ADDR: o_bus_req=1. On i_bus_gnt, drop req and go to DATA.
- DATA
  - On i_bus_rvalid, capture i_bus_rdata into o_core_rdata and go to DONE.
  - For writes, o_core_rdata is left unchanged.
  - If i_bus_err is set with rvalid, set o_err and capture o_err_addr if o_err was 0.
- DONE: go to IDLE unconditionally, so the core can present its next access.
- o_core_ready = (state==DONE) | (state==IDLE & !(rd_en|wr_en)); this is combinational.
- Watchdog
  - A 16-bit counter clears on IDLE→ADDR and increments each cycle in ADDR or DATA.
  - When count==TIMEOUT_CYCLES-1 without completion: drop req, force o_core_rdata=0, set o_err (with address capture), go to DONE.
- Any rvalid seen in IDLE, ADDR-before-gnt or DONE (for example a late response after a timeout) is ignored.
- Bus output registers hold their last value outside ADDR. Only o_bus_req is qualifying.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - o_bus_req 0, o_bus_we 0, o_bus_addr 0, o_bus_be 0, o_bus_wdata 0.
  - o_core_rdata 0, o_err 0, o_err_addr 0.
  - o_core_ready 1 with no request present.
- Zero-wait latency: request seen at cycle 0 → req high cycle 1 (gnt) → rvalid cycle 2 → DONE/ready high cycle 3. Total stall is 3 cycles.
- Each cycle gnt or rvalid is late adds exactly one stall cycle.
- A back-to-back access re-enters ADDR one cycle after DONE's IDLE cycle.
- Reset asserted mid-transaction: the next edge returns the block to IDLE with req=0. The bus slave must tolerate the abandoned request.
- Timeout with TIMEOUT_CYCLES=N: DONE is reached at request cycle + N + 1.

## Configuration
- RISCV_DMB_BE_CHECK_EN defined:
  - Legal i_core_be values are 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - Any other value in IDLE skips ADDR/DATA: no bus request is issued. The block goes straight to DONE with o_core_rdata=0 and sets o_err plus o_err_addr.
- RISCV_DMB_BE_CHECK_EN undefined: every be value, including 0000, is forwarded to the bus unchecked.

## Structure
- Shared package riscv_definitions gains:
  - dmb_state_e, an enum of the four states.
  - DMB_TIMEOUT_DEFAULT = 255.
  - BUS_ADDR_ALIGN_MASK = 32'hFFFF_FFFC.
- One sub-module, dmb_watchdog: holds the counter plus the terminal-count flag, with inputs clear, run and the limit.

## Test plan
- Load, addr 0x1000_0006, be 1100, gnt and rvalid immediate, rdata 0xDEAD_BEEF → o_bus_addr 0x1000_0004; o_core_ready low 3 cycles; rdata 0xDEAD_BEEF in the DONE cycle.
- Store, wdata 0x1234_5678, be 1111, gnt delayed 4 cycles → req held 5 cycles; o_bus_we 1; ready rises exactly one cycle after rvalid.
- TIMEOUT_CYCLES=8, no gnt → req drops; DONE at cycle 9; o_core_rdata 0; o_err 1; o_err_addr equals request address.
- rvalid with i_bus_err=1, then a second erroring access → o_err 1; o_err_addr keeps the first address.
- With RISCV_DMB_BE_CHECK_EN, be 0101 → o_bus_req never asserts; ready high at cycle 1; o_err 1. Without the macro → a normal bus transaction with be 0101.
- Reset asserted in the DATA state → next cycle IDLE, req 0; a stray rvalid afterwards leaves o_core_rdata and o_err unchanged.
